// File: rtl/mesi_line_ctrl.sv
// rtl/mesi_line_ctrl.sv - MESI coherence controller for one cache's line-state array
//
// Ports:
//   clk, rst                       rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd/cmd_idx command handshake (PR_RD, PR_WR, SN_*, CLEAR, NOP)
//   bus_req_valid/op/idx           registered bus operation, held until bus_done
//   bus_done, bus_snoop_res        bus completion pulse and other caches' snoop result
//   snoop_res_valid, snoop_res     our snoop result, one cycle after an SN_* accept
//   done, hit, state_out           retirement pulse, prior validity, final line state
//   dbg_idx, dbg_state             combinational peek into the state array
module mesi_line_ctrl #(
  parameter int NUM_LINES = 16384,
  parameter int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd,
  input  logic [IDX_W-1:0] cmd_idx,
  output logic             bus_req_valid,
  output logic [1:0]       bus_req_op,
  output logic [IDX_W-1:0] bus_req_idx,
  input  logic             bus_done,
  input  logic [1:0]       bus_snoop_res,
  output logic             snoop_res_valid,
  output logic [1:0]       snoop_res,
  output logic             done,
  output logic             hit,
  output logic [1:0]       state_out,
  input  logic [IDX_W-1:0] dbg_idx,
  output logic [1:0]       dbg_state
);

  localparam logic [2:0] C_PR_RD   = 3'd0;
  localparam logic [2:0] C_PR_WR   = 3'd1;
  localparam logic [2:0] C_SN_RD   = 3'd2;
  localparam logic [2:0] C_SN_WR   = 3'd3;
  localparam logic [2:0] C_SN_RWIM = 3'd4;
  localparam logic [2:0] C_SN_INV  = 3'd5;
  localparam logic [2:0] C_CLEAR   = 3'd6;

  localparam logic [1:0] ST_M = 2'd0;
  localparam logic [1:0] ST_E = 2'd1;
  localparam logic [1:0] ST_S = 2'd2;
  localparam logic [1:0] ST_I = 2'd3;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_INV   = 2'd2;
  localparam logic [1:0] OP_RWIM  = 2'd3;

  localparam logic [1:0] R_HIT   = 2'd0;
  localparam logic [1:0] R_HITM  = 2'd1;
  localparam logic [1:0] R_NOHIT = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);

  typedef enum logic [1:0] {IDLE, BUS_WAIT, RESP, CLEAR_SWEEP} fsm_t;

  fsm_t             fsm;
  logic [1:0]       lines [NUM_LINES];
  logic [2:0]       cmd_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] sweep_cnt;

  logic [1:0] cur;
  logic       dec_bus;
  logic [1:0] dec_op;
  logic [1:0] dec_next;
  logic       dec_snoop;
  logic [1:0] dec_sres;
  logic [1:0] bus_final;

  assign dbg_state = lines[dbg_idx];
  assign cur       = lines[cmd_idx];

  // Decode of the incoming command against the current line state. Either
  // the command completes locally with dec_next, or it needs a bus op.
  always_comb begin
    dec_bus   = 1'b0;
    dec_op    = OP_READ;
    dec_next  = cur;
    dec_snoop = 1'b0;
    dec_sres  = R_NOHIT;
    case (cmd)
      C_PR_RD: begin
        if (cur == ST_I) begin
          dec_bus = 1'b1;
          dec_op  = OP_READ;
        end
      end
      C_PR_WR: begin
        case (cur)
          ST_M, ST_E: dec_next = ST_M;
          ST_S: begin dec_bus = 1'b1; dec_op = OP_INV;  end
          default: begin dec_bus = 1'b1; dec_op = OP_RWIM; end
        endcase
      end
      C_SN_RD: begin
        dec_snoop = 1'b1;
        case (cur)
          ST_M: begin dec_sres = R_HITM; dec_bus = 1'b1; dec_op = OP_WRITE; end
          ST_E, ST_S: begin dec_sres = R_HIT; dec_next = ST_S; end
          default: dec_sres = R_NOHIT;
        endcase
      end
      C_SN_WR: begin
        dec_snoop = 1'b1;
        dec_sres  = (cur != ST_I) ? R_HIT : R_NOHIT;
      end
      C_SN_RWIM: begin
        dec_snoop = 1'b1;
        case (cur)
          ST_M: begin dec_sres = R_HITM; dec_bus = 1'b1; dec_op = OP_WRITE; end
          ST_E, ST_S: begin dec_sres = R_HIT; dec_next = ST_I; end
          default: dec_sres = R_NOHIT;
        endcase
      end
      C_SN_INV: begin
        dec_snoop = 1'b1;
        case (cur)
          ST_S: begin dec_sres = R_HIT; dec_next = ST_I; end
          // M/E receiving an invalidate is a protocol violation; keep the line.
          ST_M, ST_E: dec_sres = R_HIT;
          default: dec_sres = R_NOHIT;
        endcase
      end
      default: ;
    endcase
  end

  // Final state committed when the bus operation completes. Only reads
  // care about the other caches' answer; the reserved code 3 counts as NOHIT.
  always_comb begin
    bus_final = ST_I;
    case (cmd_q)
      C_PR_RD: bus_final = (bus_snoop_res == R_HIT || bus_snoop_res == R_HITM) ? ST_S : ST_E;
      C_PR_WR: bus_final = ST_M;
      C_SN_RD: bus_final = ST_S;
      default: bus_final = ST_I;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm             <= IDLE;
      cmd_ready       <= 1'b1;
      bus_req_valid   <= 1'b0;
      bus_req_op      <= OP_READ;
      bus_req_idx     <= '0;
      snoop_res_valid <= 1'b0;
      snoop_res       <= R_NOHIT;
      done            <= 1'b0;
      hit             <= 1'b0;
      state_out       <= ST_I;
      cmd_q           <= '0;
      idx_q           <= '0;
      sweep_cnt       <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        lines[i] <= ST_I;
      end
    end else begin
      done            <= 1'b0;
      snoop_res_valid <= 1'b0;
      case (fsm)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            cmd_q     <= cmd;
            idx_q     <= cmd_idx;
            hit       <= (cur != ST_I);
            if (cmd == C_CLEAR) begin
              hit       <= 1'b0;
              sweep_cnt <= '0;
              fsm       <= CLEAR_SWEEP;
            end else begin
              // Snoop answer goes out immediately, even if a writeback follows.
              snoop_res_valid <= dec_snoop;
              if (dec_snoop) snoop_res <= dec_sres;
              if (dec_bus) begin
                bus_req_valid <= 1'b1;
                bus_req_op    <= dec_op;
                bus_req_idx   <= cmd_idx;
                fsm           <= BUS_WAIT;
              end else begin
                lines[cmd_idx] <= dec_next;
                state_out      <= dec_next;
                done           <= 1'b1;
                fsm            <= RESP;
              end
            end
          end
        end
        BUS_WAIT: begin
          if (bus_done) begin
            bus_req_valid <= 1'b0;
            lines[idx_q]  <= bus_final;
            state_out     <= bus_final;
            done          <= 1'b1;
            fsm           <= RESP;
          end
        end
        RESP: begin
          cmd_ready <= 1'b1;
          fsm       <= IDLE;
        end
        CLEAR_SWEEP: begin
          lines[sweep_cnt] <= ST_I;
          // Stop at the terminal index rather than letting the counter wrap.
          if (sweep_cnt == LAST_IDX) begin
            state_out <= ST_I;
            done      <= 1'b1;
            fsm       <= RESP;
          end else begin
            sweep_cnt <= sweep_cnt + IDX_W'(1);
          end
        end
        default: begin
          cmd_ready <= 1'b1;
          fsm       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mesi_line_ctrl.sv
// tb/tb_mesi_line_ctrl.sv - scoreboard testbench for mesi_line_ctrl
module tb_mesi_line_ctrl;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd = 3'd0;
  logic [W-1:0] cmd_idx = '0;
  logic         bus_req_valid;
  logic [1:0]   bus_req_op;
  logic [W-1:0] bus_req_idx;
  logic         bus_done = 1'b0;
  logic [1:0]   bus_snoop_res = 2'd2;
  logic         snoop_res_valid;
  logic [1:0]   snoop_res;
  logic         done;
  logic         hit;
  logic [1:0]   state_out;
  logic [W-1:0] dbg_idx = '0;
  logic [1:0]   dbg_state;

  int vectors = 0;
  int miscompares = 0;

  logic [2:0] exp_done_q [$];
  logic [1:0] exp_snp_q [$];
  logic [2:0] mon_e;
  logic [1:0] mon_s;

  always #5 clk = ~clk;

  mesi_line_ctrl #(.NUM_LINES(N), .IDX_W(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd), .cmd_idx(cmd_idx),
    .bus_req_valid(bus_req_valid), .bus_req_op(bus_req_op), .bus_req_idx(bus_req_idx),
    .bus_done(bus_done), .bus_snoop_res(bus_snoop_res),
    .snoop_res_valid(snoop_res_valid), .snoop_res(snoop_res),
    .done(done), .hit(hit), .state_out(state_out),
    .dbg_idx(dbg_idx), .dbg_state(dbg_state)
  );

  // Scoreboard: retirement and snoop pulses are matched against expectations
  // queued when the command was driven.
  always @(negedge clk) begin
    if (!rst) begin
      if (done === 1'b1) begin
        vectors++;
        if (exp_done_q.size() == 0) begin
          miscompares++;
          $display("FAIL done_unexpected got hit=%b state=%0d want no retirement", hit, state_out);
        end else begin
          mon_e = exp_done_q.pop_front();
          if ({hit, state_out} !== mon_e) begin
            miscompares++;
            $display("FAIL done_result got hit=%b state=%0d want hit=%b state=%0d",
                     hit, state_out, mon_e[2], mon_e[1:0]);
          end
        end
      end
      if (snoop_res_valid === 1'b1) begin
        vectors++;
        if (exp_snp_q.size() == 0) begin
          miscompares++;
          $display("FAIL snoop_unexpected got res=%0d want no snoop pulse", snoop_res);
        end else begin
          mon_s = exp_snp_q.pop_front();
          if (snoop_res !== mon_s) begin
            miscompares++;
            $display("FAIL snoop_res got %0d want %0d", snoop_res, mon_s);
          end
        end
      end
    end
  end

  task automatic issue(input logic [2:0] c, input logic [W-1:0] i,
                       input logic eh, input logic [1:0] es,
                       input bit snp, input logic [1:0] esr);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd       = c;
    cmd_idx   = i;
    exp_done_q.push_back({eh, es});
    if (snp) exp_snp_q.push_back(esr);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic expect_local(input string tag);
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || bus_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_local got done=%b busv=%b want done=1 busv=0", tag, done, bus_req_valid);
    end
  endtask

  task automatic service_bus(input logic [1:0] op, input logic [W-1:0] i,
                             input logic [1:0] res, input string tag);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (bus_req_valid !== 1'b1 || bus_req_op !== op || bus_req_idx !== i || done !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_busreq cyc%0d got v=%b op=%0d idx=%0d done=%b want v=1 op=%0d idx=%0d done=0",
                 tag, k, bus_req_valid, bus_req_op, bus_req_idx, done, op, i);
      end
    end
    bus_done      = 1'b1;
    bus_snoop_res = res;
    @(posedge clk);
    #1 bus_done = 1'b0;
    bus_snoop_res = 2'd2;
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || bus_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_busdone got done=%b busv=%b want done=1 busv=0", tag, done, bus_req_valid);
    end
  endtask

  task automatic peek(input logic [W-1:0] i, input logic [1:0] es, input string tag);
    dbg_idx = i;
    #1;
    vectors++;
    if (dbg_state !== es) begin
      miscompares++;
      $display("FAIL %s_dbg line%0d got %0d want %0d", tag, i, dbg_state, es);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    peek(3'd0, 2'd3, "reset");
    peek(3'd5, 2'd3, "reset");
    peek(3'd7, 2'd3, "reset");
    vectors++;
    if (cmd_ready !== 1'b1 || bus_req_valid !== 1'b0 || done !== 1'b0 ||
        snoop_res_valid !== 1'b0 || snoop_res !== 2'd2 || state_out !== 2'd3 || hit !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got rdy=%b busv=%b done=%b sv=%b sr=%0d st=%0d hit=%b want 1 0 0 0 2 3 0",
               cmd_ready, bus_req_valid, done, snoop_res_valid, snoop_res, state_out, hit);
    end
  endtask

  task automatic test_pr_rd();
    issue(3'd0, 3'd5, 1'b0, 2'd1, 0, 2'd0);
    service_bus(2'd0, 3'd5, 2'd2, "prrd_nohit");
    peek(3'd5, 2'd1, "prrd_nohit");
    issue(3'd0, 3'd7, 1'b0, 2'd2, 0, 2'd0);
    service_bus(2'd0, 3'd7, 2'd1, "prrd_hitm");
    peek(3'd7, 2'd2, "prrd_hitm");
    issue(3'd0, 3'd5, 1'b1, 2'd1, 0, 2'd0);
    expect_local("prrd_hit");
  endtask

  task automatic test_pr_wr();
    issue(3'd1, 3'd5, 1'b1, 2'd0, 0, 2'd0);
    expect_local("prwr_e");
    issue(3'd1, 3'd7, 1'b1, 2'd0, 0, 2'd0);
    service_bus(2'd2, 3'd7, 2'd0, "prwr_s");
    issue(3'd1, 3'd2, 1'b0, 2'd0, 0, 2'd0);
    service_bus(2'd3, 3'd2, 2'd1, "prwr_i");
    @(negedge clk);
    peek(3'd2, 2'd0, "prwr_i");
  endtask

  task automatic test_snoop();
    issue(3'd2, 3'd5, 1'b1, 2'd2, 1, 2'd1);
    service_bus(2'd1, 3'd5, 2'd2, "snrd_m");
    peek(3'd5, 2'd2, "snrd_m");
    issue(3'd4, 3'd5, 1'b1, 2'd3, 1, 2'd0);
    expect_local("snrwim_s");
    issue(3'd5, 3'd5, 1'b0, 2'd3, 1, 2'd2);
    expect_local("sninv_i");
    issue(3'd3, 3'd7, 1'b1, 2'd0, 1, 2'd0);
    expect_local("snwr_m");
    issue(3'd5, 3'd2, 1'b1, 2'd0, 1, 2'd0);
    expect_local("sninv_m");
  endtask

  task automatic test_nop();
    issue(3'd7, 3'd2, 1'b1, 2'd0, 0, 2'd0);
    expect_local("nop");
    // A bus_done outside BUS_WAIT must not disturb anything.
    @(negedge clk);
    bus_done = 1'b1;
    @(posedge clk);
    #1 bus_done = 1'b0;
    @(negedge clk);
    peek(3'd2, 2'd0, "stray_done");
    vectors++;
    if (done !== 1'b0 || bus_req_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stray_done got done=%b busv=%b rdy=%b want 0 0 1", done, bus_req_valid, cmd_ready);
    end
  endtask

  task automatic test_clear();
    issue(3'd1, 3'd0, 1'b0, 2'd0, 0, 2'd0);
    service_bus(2'd3, 3'd0, 2'd2, "dirty0");
    issue(3'd6, 3'd0, 1'b0, 2'd3, 0, 2'd0);
    for (int k = 1; k <= N + 1; k++) begin
      @(negedge clk);
      vectors++;
      if (done !== (k == N + 1) || cmd_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL clear_timing cyc%0d got done=%b rdy=%b want done=%b rdy=0",
                 k, done, cmd_ready, (k == N + 1));
      end
    end
    for (int i = 0; i < N; i++) peek(W'(i), 2'd3, "clear");
  endtask

  task automatic test_reset_mid();
    issue(3'd1, 3'd4, 1'b0, 2'd0, 0, 2'd0);
    @(negedge clk);
    vectors++;
    if (bus_req_valid !== 1'b1 || bus_req_op !== 2'd3) begin
      miscompares++;
      $display("FAIL rstmid_busreq got v=%b op=%0d want v=1 op=3", bus_req_valid, bus_req_op);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_done_q.delete();
    exp_snp_q.delete();
    @(negedge clk);
    peek(3'd4, 2'd3, "rstmid");
    vectors++;
    if (bus_req_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_abort got busv=%b rdy=%b want 0 1", bus_req_valid, cmd_ready);
    end
    bus_done = 1'b1;
    @(posedge clk);
    #1 bus_done = 1'b0;
    @(negedge clk);
    peek(3'd4, 2'd3, "rstmid_stale");
    vectors++;
    if (done !== 1'b0 || bus_req_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_stale got done=%b busv=%b rdy=%b want 0 0 1", done, bus_req_valid, cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    issue(3'd0, 3'd3, 1'b0, 2'd2, 0, 2'd0);
    service_bus(2'd0, 3'd3, 2'd0, "b2b_rd");
    issue(3'd1, 3'd3, 1'b1, 2'd0, 0, 2'd0);
    service_bus(2'd2, 3'd3, 2'd2, "b2b_wr");
    issue(3'd4, 3'd3, 1'b1, 2'd3, 1, 2'd1);
    service_bus(2'd1, 3'd3, 2'd0, "b2b_rwim");
    @(negedge clk);
    peek(3'd3, 2'd3, "b2b_rwim");
  endtask

  initial begin
    test_reset();
    test_pr_rd();
    test_pr_wr();
    test_snoop();
    test_nop();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    vectors++;
    if (exp_done_q.size() != 0 || exp_snp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got done_left=%0d snoop_left=%0d want 0 0",
               exp_done_q.size(), exp_snp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
